// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous double
// buffering, per-slot PWM brightness and per-digit blinking.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000,
  parameter int BRIGHT_W   = 3,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6*NUM_DIGITS-1:0] digit_data,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int SUB_LEN = TICK_DIV >> BRIGHT_W;
  localparam int SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BC_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DW      = 6 * NUM_DIGITS;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [SUB_W-1:0]      sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_W-1:0]   phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic [BC_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [DW-1:0]         act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            sseg_q, sseg_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;

  logic       sub_wrap, slot_wrap, frame_start, lit;
  logic [5:0] fld;

  always_comb begin
    sub_wrap    = (sub_cnt_q == SUB_W'(SUB_LEN - 1));
    slot_wrap   = sub_wrap && (phase_q == '1);
    frame_start = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

    sub_cnt_d    = sub_wrap ? '0 : sub_cnt_q + 1'b1;
    phase_d      = sub_wrap ? phase_q + 1'b1 : phase_q;
    idx_d        = idx_q;
    bright_d     = bright_q;
    blink_cnt_d  = blink_cnt_q;
    blink_ph_d   = blink_ph_q;
    act_data_d   = act_data_q;
    act_mask_d   = act_mask_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    pending_d    = pending_q;
    frame_tick_d = frame_start;

    if (slot_wrap) begin
      idx_d    = frame_start ? '0 : idx_q + 1'b1;
      bright_d = brightness;
    end

    // Buffer swap and blink accounting only happen on the frame boundary.
    if (frame_start) begin
      if (pending_q) begin
        act_data_d = pend_data_q;
        act_mask_d = pend_mask_q;
        pending_d  = 1'b0;
      end
      if (blink_cnt_q == BC_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // A load on the boundary lands after the swap, so it stays pending.
    if (load) begin
      pend_data_d = digit_data;
      pend_mask_d = blink_mask;
      pending_d   = 1'b1;
    end

    fld = act_data_q[6*int'(idx_q) +: 6];
    lit = fld[5] && !(blink_ph_q && act_mask_q[idx_q]) && (phase_q <= bright_q);
    an_d   = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    sseg_d = lit ? hex7(fld[4:1]) : 7'h7F;
    dp_d   = lit ? ~fld[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_cnt_q    <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      bright_q     <= brightness;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      act_data_q   <= '0;
      act_mask_q   <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      sub_cnt_q    <= sub_cnt_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      bright_q     <= bright_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      act_data_q   <= act_data_d;
      act_mask_q   <= act_mask_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sseg       = sseg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed scenarios plus random traffic checked
// against a cycle-count based reference model.
module tb_sseg_scan_ctrl;
  localparam int ND = 4, TD = 8, BW = 2, BD = 2;
  localparam int SLOT = TD, FRAME = TD * ND, SUBL = TD / (1 << BW);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6*ND-1:0] digit_data = '0;
  logic          load = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic [BW-1:0] brightness = '1;
  logic [6:0]    sseg;
  logic          dp;
  logic [ND-1:0] an;
  logic          pending;
  logic          frame_tick;

  sseg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BRIGHT_W(BW), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .digit_data(digit_data), .load(load),
    .blink_mask(blink_mask), .brightness(brightness), .sseg(sseg), .dp(dp),
    .an(an), .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int tests = 0, fails = 0;
  int cnt;                       // clock edges since the last reset edge
  logic [6*ND-1:0] m_act, m_pend;
  logic [ND-1:0]   m_amask, m_pmask;
  logic            m_pending;
  logic [BW-1:0]   m_bright;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (cnt=%0d)", tag, got, exp, cnt);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    cnt = 0; m_act = '0; m_pend = '0; m_amask = '0; m_pmask = '0;
    m_pending = 1'b0; m_bright = brightness;
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_sseg", 16'(sseg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    reset = 1'b0;
  endtask

  // One clock: the outputs after this edge describe the model state before it.
  task automatic step();
    int digit, sub, frm;
    logic [5:0] fld;
    logic lit, ld;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    logic [6*ND-1:0] dnew;
    logic [ND-1:0] mnew;
    logic [BW-1:0] bnew;
    digit = (cnt / SLOT) % ND;
    sub   = (cnt % SLOT) / SUBL;
    frm   = cnt / FRAME;
    fld   = m_act[digit*6 +: 6];
    lit   = fld[5] && !(((frm / BD) % 2 == 1) && m_amask[digit]) && (sub <= int'(m_bright));
    e_an  = lit ? ~(4'b0001 << digit) : 4'hF;
    e_seg = lit ? seg_tab[fld[4:1]] : 7'h7F;
    e_dp  = lit ? ~fld[0] : 1'b1;
    ld = load; dnew = digit_data; mnew = blink_mask; bnew = brightness;
    @(posedge clk);
    cnt++;
    if (cnt % FRAME == 0 && m_pending) begin
      m_act = m_pend; m_amask = m_pmask; m_pending = 1'b0;
    end
    if (ld) begin
      m_pend = dnew; m_pmask = mnew; m_pending = 1'b1;
    end
    if (cnt % SLOT == 0) m_bright = bnew;
    #1;
    chk("an", 16'(an), 16'(e_an));
    chk("sseg", 16'(sseg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("pending", 16'(pending), 16'(m_pending));
    chk("frame_tick", 16'(frame_tick), 16'(cnt % FRAME == 0));
  endtask

  task automatic run_to(input int target);
    while (cnt < target) step();
  endtask

  task automatic pulse_load(input logic [6*ND-1:0] d, input logic [ND-1:0] m);
    digit_data = d; blink_mask = m; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Basic display: digits 1, 8, A (with point), F at full brightness.
    brightness = 2'd3;
    do_reset();
    pulse_load({1'b1, 4'hF, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 4'h1, 1'b0}, 4'b0000);
    run_to(FRAME + 1);
    chk("d0_an", 16'(an), 16'h000E);
    chk("d0_seg", 16'(sseg), 16'h0079);
    run_to(FRAME + 2 * SLOT + 1);
    chk("d2_seg", 16'(sseg), 16'h0008);
    chk("d2_dp", 16'(dp), 16'h0000);
    run_to(2 * FRAME);

    // Mid-frame load, then a load exactly on the frame boundary.
    run_to(2 * FRAME + 5);
    pulse_load({1'b0, 4'h3, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 4'h7, 1'b1}, 4'b0000);
    run_to(3 * FRAME - 1);
    pulse_load({1'b1, 4'h2, 1'b1, 1'b1, 4'hC, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 4'hE, 1'b0}, 4'b0010);
    run_to(5 * FRAME);

    // Dimming levels, then blinking on digit 1 across several frames.
    brightness = 2'd0;
    run_to(6 * FRAME);
    brightness = 2'd1;
    run_to(7 * FRAME);
    brightness = 2'd3;
    run_to(11 * FRAME);

    // Reset mid-frame while a load is pending.
    run_to(11 * FRAME + 9);
    pulse_load('1, 4'b1111);
    do_reset();
    run_to(2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 1200; i++) begin
      digit_data = 24'($urandom);
      blink_mask = 4'($urandom);
      brightness = 2'($urandom);
      load = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 600) == 0) do_reset();
      else step();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
